// File: rtl/lsu_mem_port_arbiter_pkg.sv
// Shared types and defaults for the LSU data-memory port arbiter.
// The port request struct is sized at the default word width.
package lsu_mem_port_arbiter_pkg;

    localparam int unsigned MEM_WORD_W       = 16;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STARVE_CNT_W     = 4;

    typedef enum logic [0:0] {
        ARB_LOAD_PRI = 1'b0,
        ARB_DRAIN    = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [MEM_WORD_W-1:0] addr;
        logic                  we;
        logic [MEM_WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/lsu_starve_counter.sv
// Saturating count of consecutive cycles a ready store lost the port to a load.
// Flags when the value about to be registered reaches the limit.
module lsu_starve_counter
    import lsu_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_next_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Clear has priority; increment saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_next_o = (cnt_d == LIMIT_C);

endmodule

// File: rtl/lsu_mem_port_arbiter.sv
// Shares the single data-memory port between LSU loads and store-buffer drains.
// Loads win by default; starvation or a full store buffer forces a DRAIN phase.
module lsu_mem_port_arbiter
    import lsu_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE_P  = MEM_WORD_W,
    parameter int unsigned SB_ENTRY     = 8,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        ld_req_v_i,
    input  logic [WORD_SIZE_P-1:0]      ld_addr_i,
    input  logic                        mispredict_i,
    input  logic                        st_req_v_i,
    input  logic [WORD_SIZE_P-1:0]      st_addr_i,
    input  logic [WORD_SIZE_P-1:0]      st_data_i,
    input  logic [$clog2(SB_ENTRY)-1:0] st_sb_num_i,
    input  logic                        sb_full_i,
    output logic                        st_ack_o,
    output logic [$clog2(SB_ENTRY)-1:0] st_ack_num_o,
    output logic                        ld_grant_o,
    output logic                        ld_stall_o,
    output logic [WORD_SIZE_P-1:0]      mem_addr_o,
    output logic                        mem_we_o,
    output logic [WORD_SIZE_P-1:0]      mem_wdata_o,
    output logic                        protocol_err_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       ld_eff;
    logic       ld_gnt;
    logic       st_gnt;
    logic       limit_next;
    logic       stall_q;
    logic       err_q;
    mem_req_t   mem_req;

    // Same-cycle grant; everything is held off while reset is asserted.
    always_comb begin
        ld_eff = ld_req_v_i & ~mispredict_i;
        ld_gnt = 1'b0;
        st_gnt = 1'b0;
        if (!reset_i) begin
            if (state_q == ARB_DRAIN) begin
                st_gnt = st_req_v_i;
                ld_gnt = ld_eff & ~st_req_v_i;
            end else begin
                ld_gnt = ld_eff;
                st_gnt = st_req_v_i & ~ld_eff;
            end
        end
    end

    always_comb begin
        mem_req.addr  = MEM_WORD_W'(ld_addr_i);
        mem_req.we    = 1'b0;
        mem_req.wdata = '0;
        if (st_gnt) begin
            mem_req.addr  = MEM_WORD_W'(st_addr_i);
            mem_req.we    = 1'b1;
            mem_req.wdata = MEM_WORD_W'(st_data_i);
        end
    end

    lsu_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clr_i        (st_gnt),
        .inc_i        (st_req_v_i & ld_gnt),
        .limit_next_o (limit_next)
    );

    // DRAIN is also left when no committed head exists, so it cannot deadlock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_LOAD_PRI: begin
                if (sb_full_i || limit_next) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (!st_req_v_i || (st_gnt && !sb_full_i)) begin
                    state_d = ARB_LOAD_PRI;
                end
            end
            default: state_d = ARB_LOAD_PRI;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ARB_LOAD_PRI;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= (state_d == ARB_DRAIN);
            if (ld_req_v_i && stall_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign st_ack_o       = st_gnt;
    assign st_ack_num_o   = st_gnt ? st_sb_num_i : '0;
    assign ld_grant_o     = ld_gnt;
    assign ld_stall_o     = stall_q;
    assign mem_addr_o     = WORD_SIZE_P'(mem_req.addr);
    assign mem_we_o       = mem_req.we;
    assign mem_wdata_o    = WORD_SIZE_P'(mem_req.wdata);
    assign protocol_err_o = err_q;

endmodule
